aes_round_sequencer: RTL and testbench

Sequences one AES-128 encryption through the shared byte-substitution stage. It counts the S-box fill stream so it knows when the substitution stage can be used. It then runs the initial AddRoundKey and ten rounds, issuing one 128-bit substitution request per round. ShiftRows, MixColumns and AddRoundKey are done locally. It sits between the plaintext/key source and the substitution stage, and is the only block that drives that stage's request port.

---
 rtl/aes_round_sequencer.sv | 167 ++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// AES-128 encryption sequencer: gates on S-box fill, then runs ARK0 and ten rounds
// through the shared substitution stage, with ShiftRows/MixColumns/AddRoundKey done locally.
module aes_round_sequencer #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned SBOX_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sbox_valid,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] plaintext,
  output logic [3:0]            key_round,
  input  logic [DATA_WIDTH-1:0] round_key,
  output logic                  sb_tvalid,
  output logic [DATA_WIDTH-1:0] sb_in,
  input  logic                  sb_valid,
  input  logic [DATA_WIDTH-1:0] sb_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ciphertext,
  output logic                  busy
);

  localparam int unsigned RND_W = 4;
  localparam int unsigned CNT_W = 9;

  typedef enum logic [2:0] {IDLE, ARK0, SUB, WAIT, DONE} state_e;

  // Byte k of the state sits at bits [DATA_WIDTH-1-8k -: 8]; row = k%4, column = k/4.
  function automatic logic [DATA_WIDTH-1:0] shift_rows(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[DATA_WIDTH-1-8*(r+4*c) -: 8] = s[DATA_WIDTH-1-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return t;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mix_columns(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] t;
    logic [7:0] a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[DATA_WIDTH-1-8*(4*c)   -: 8];
      a1 = s[DATA_WIDTH-1-8*(4*c+1) -: 8];
      a2 = s[DATA_WIDTH-1-8*(4*c+2) -: 8];
      a3 = s[DATA_WIDTH-1-8*(4*c+3) -: 8];
      t[DATA_WIDTH-1-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      t[DATA_WIDTH-1-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      t[DATA_WIDTH-1-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      t[DATA_WIDTH-1-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return t;
  endfunction

  state_e                state_q, state_d;
  logic [RND_W-1:0]      round_q, round_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  loaded_q, loaded_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  in_ready_q, in_ready_d;
  logic                  sb_tvalid_q, sb_tvalid_d;
  logic [DATA_WIDTH-1:0] sb_in_q, sb_in_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] ciphertext_q, ciphertext_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] t;

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    sb_in_d      = sb_in_q;
    t            = '0;

    // Fill counter freezes once the S-box is known to be complete.
    if (sbox_valid && !loaded_q) cnt_d = cnt_q + CNT_W'(1);
    loaded_d = loaded_q | (cnt_d == CNT_W'(SBOX_DEPTH));

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d  = plaintext;
          round_d = '0;
          state_d = ARK0;
        end
      end
      ARK0: begin
        data_d  = data_q ^ round_key;
        round_d = RND_W'(1);
        state_d = SUB;
      end
      SUB: state_d = WAIT;
      WAIT: begin
        if (sb_valid) begin
          t = shift_rows(sb_out);
          if (round_q < RND_W'(NUM_ROUNDS)) t = mix_columns(t);
          data_d = t ^ round_key;
          if (round_q == RND_W'(NUM_ROUNDS)) begin
            state_d = DONE;
          end else begin
            round_d = round_q + RND_W'(1);
            state_d = SUB;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    in_ready_d   = (state_d == IDLE) && loaded_d;
    sb_tvalid_d  = (state_d == SUB);
    if (state_d == SUB) sb_in_d = data_d;
    out_valid_d  = (state_d == DONE);
    ciphertext_d = (state_d == DONE) ? data_d : '0;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      round_q      <= '0;
      cnt_q        <= '0;
      loaded_q     <= 1'b0;
      data_q       <= '0;
      in_ready_q   <= 1'b0;
      sb_tvalid_q  <= 1'b0;
      sb_in_q      <= '0;
      out_valid_q  <= 1'b0;
      ciphertext_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      cnt_q        <= cnt_d;
      loaded_q     <= loaded_d;
      data_q       <= data_d;
      in_ready_q   <= in_ready_d;
      sb_tvalid_q  <= sb_tvalid_d;
      sb_in_q      <= sb_in_d;
      out_valid_q  <= out_valid_d;
      ciphertext_q <= ciphertext_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign key_round  = round_q;
  assign sb_tvalid  = sb_tvalid_q;
  assign sb_in      = sb_in_q;
  assign out_valid  = out_valid_q;
  assign ciphertext = ciphertext_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: key schedule and substitution stage modelled
// here, expected ciphertexts queued at accept and compared when the block comes out.
module tb_aes_round_sequencer;

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         reset_n;
  logic         sbox_valid;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [3:0]   key_round;
  logic [127:0] round_key;
  logic         sb_tvalid;
  logic [127:0] sb_in;
  logic         sb_valid;
  logic [127:0] sb_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;
  logic [127:0] exp_q[$];

  logic [7:0]   sbox [0:255];
  logic [127:0] rk [0:10];

  // Substitution-stage model state
  int           cd = 0;
  int           tv_count = 0;
  int           stall_req = -1;
  logic [127:0] pend = '0;
  logic         sb_valid_r = 1'b0;
  logic [127:0] sb_out_r = '0;
  logic         spur = 1'b0;
  logic [127:0] spur_data = '0;

  aes_round_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sbox_valid (sbox_valid),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key_round  (key_round),
    .round_key  (round_key),
    .sb_tvalid  (sb_tvalid),
    .sb_in      (sb_in),
    .sb_valid   (sb_valid),
    .sb_out     (sb_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign round_key = (key_round <= 4'd10) ? rk[key_round] : '0;
  assign sb_valid  = sb_valid_r | spur;
  assign sb_out    = spur ? spur_data : sb_out_r;

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox[s[127-8*k -: 8]];
    return o;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Substitution stage: answers each request one cycle later (or later for the stalled request).
  always @(negedge clk) begin
    sb_valid_r = 1'b0;
    if (!reset_n) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          sb_valid_r = 1'b1;
          sb_out_r   = pend;
        end
      end
      if (sb_tvalid) begin
        tv_count = tv_count + 1;
        pend = sub_bytes(sb_in);
        cd = (tv_count == stall_req) ? 5 : 1;
      end
    end
  end

  task automatic do_accept(input logic [127:0] pt, input logic [127:0] exp_ct, output bit to);
    int n;
    n = 0; to = 1'b0;
    plaintext = pt;
    in_valid  = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) to = 1'b1;
    else begin
      exp_q.push_back(exp_ct);
      t_acc = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [127:0] ct, output int lat, output bit to);
    int n;
    n = 0; to = 1'b0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) to = 1'b1;
    ct  = ciphertext;
    lat = cyc - t_acc;
  endtask

  function automatic logic [127:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; sbox_valid = 1'b0; out_ready = 1'b1; plaintext = '0;
    set_key(KEY_C1);
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, sb_tvalid, out_valid, busy, key_round} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000000", {in_ready, sb_tvalid, out_valid, busy, key_round});
    end
    checks++;
    if (sb_in !== '0) begin errors++; $display("FAIL reset_sb_in got %h want 0", sb_in); end
    checks++;
    if (ciphertext !== '0) begin errors++; $display("FAIL reset_ct got %h want 0", ciphertext); end
    reset_n = 1'b1;
  endtask

  task automatic test_fill_and_c1();
    logic [127:0] ct, ex;
    int lat, tv0;
    bit to;
    set_key(KEY_C1);
    plaintext = PT_C1;
    in_valid  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_gate after %0d pulses in_ready got %b want 0", i, in_ready); end
      sbox_valid = 1'b1;
    end
    @(negedge clk);
    sbox_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready got %b want 1", in_ready); end
    exp_q.push_back(CT_C1);
    t_acc = cyc;
    tv0 = tv_count;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({busy, key_round} !== 5'b1_0000) begin errors++; $display("FAIL ark0_state busy/key_round got %b want 10000", {busy, key_round}); end
    wait_out(ct, lat, to);
    checks++;
    if (to) begin errors++; $display("FAIL c1_timeout out_valid got 0 want 1"); end
    checks++;
    if (lat != 22) begin errors++; $display("FAIL c1_latency got %0d want 22", lat); end
    ex = pop_exp();
    checks++;
    if (ct !== ex) begin errors++; $display("FAIL c1_ct got %h want %h", ct, ex); end
    checks++;
    if (tv_count - tv0 != 10) begin errors++; $display("FAIL c1_requests got %0d want 10", tv_count - tv0); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [127:0] ct, ex;
    int lat, tv0;
    bit to;
    set_key(KEY_C1);
    tv0 = tv_count;
    stall_req = tv_count + 3;
    do_accept(PT_C1, CT_C1, to);
    checks++;
    if (to) begin errors++; $display("FAIL stall_accept in_ready got 0 want 1"); end
    wait_out(ct, lat, to);
    stall_req = -1;
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout out_valid got 0 want 1"); end
    checks++;
    if (lat != 26) begin errors++; $display("FAIL stall_latency got %0d want 26", lat); end
    ex = pop_exp();
    checks++;
    if (ct !== ex) begin errors++; $display("FAIL stall_ct got %h want %h", ct, ex); end
    checks++;
    if (tv_count - tv0 != 10) begin errors++; $display("FAIL stall_requests got %0d want 10", tv_count - tv0); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [127:0] ct, ex, first;
    int lat;
    bit to;
    set_key(KEY_C1);
    out_ready = 1'b0;
    do_accept(PT_C1, CT_C1, to);
    wait_out(ct, lat, to);
    checks++;
    if (to) begin errors++; $display("FAIL bp_timeout out_valid got 0 want 1"); end
    first = ct;
    ex = pop_exp();
    checks++;
    if (ct !== ex) begin errors++; $display("FAIL bp_ct1 got %h want %h", ct, ex); end
    set_key(KEY_B);
    plaintext = PT_B;
    in_valid  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || ciphertext !== first) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got %b/%h want 1/%h", i, out_valid, ciphertext, first);
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release out_valid/in_ready got %b want 01", {out_valid, in_ready}); end
    exp_q.push_back(CT_B);
    t_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(ct, lat, to);
    checks++;
    if (to || lat != 22) begin errors++; $display("FAIL bp_latency2 got %0d want 22", lat); end
    ex = pop_exp();
    checks++;
    if (ct !== ex) begin errors++; $display("FAIL bp_ct2 got %h want %h", ct, ex); end
    @(negedge clk);
  endtask

  task automatic test_spurious();
    logic [127:0] ct, ex;
    int lat, tv0;
    bit to;
    set_key(KEY_C1);
    out_ready = 1'b0;
    tv0 = tv_count;
    spur_data = {$urandom, $urandom, $urandom, $urandom};
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    checks++;
    if ({busy, in_ready} !== 2'b01) begin errors++; $display("FAIL spur_idle busy/in_ready got %b want 01", {busy, in_ready}); end
    do_accept(PT_C1, CT_C1, to);
    spur_data = {$urandom, $urandom, $urandom, $urandom};
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    checks++;
    if ({sb_tvalid, key_round} !== 5'b1_0001) begin errors++; $display("FAIL spur_ark0 sb_tvalid/key_round got %b want 10001", {sb_tvalid, key_round}); end
    wait_out(ct, lat, to);
    checks++;
    if (to || lat != 22) begin errors++; $display("FAIL spur_latency got %0d want 22", lat); end
    ex = pop_exp();
    checks++;
    if (ct !== ex) begin errors++; $display("FAIL spur_ct got %h want %h", ct, ex); end
    spur_data = {$urandom, $urandom, $urandom, $urandom};
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ciphertext !== ex) begin errors++; $display("FAIL spur_done got %b/%h want 1/%h", out_valid, ciphertext, ex); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL spur_release out_valid got %b want 0", out_valid); end
    checks++;
    if (tv_count - tv0 != 10) begin errors++; $display("FAIL spur_requests got %0d want 10", tv_count - tv0); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] ct, ex;
    int lat, n;
    bit to;
    set_key(KEY_C1);
    out_ready = 1'b1;
    do_accept(PT_C1, CT_C1, to);
    n = 0;
    while (key_round !== 4'd6 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_round !== 4'd6) begin errors++; $display("FAIL rmid_reach key_round got %0d want 6", key_round); end
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({in_ready, sb_tvalid, out_valid, busy, key_round} !== 8'h00) begin
      errors++;
      $display("FAIL rmid_ctrl got %b want 00000000", {in_ready, sb_tvalid, out_valid, busy, key_round});
    end
    checks++;
    if (sb_in !== '0 || ciphertext !== '0) begin errors++; $display("FAIL rmid_data got %h/%h want 0/0", sb_in, ciphertext); end
    @(negedge clk);
    reset_n = 1'b1;
    plaintext = PT_B;
    in_valid  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, busy} !== 2'b00) begin errors++; $display("FAIL rmid_no_refill in_ready/busy got %b want 00", {in_ready, busy}); end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      sbox_valid = 1'b1;
    end
    @(negedge clk);
    sbox_valid = 1'b0;
    set_key(KEY_B);
    do_accept(PT_B, CT_B, to);
    checks++;
    if (to) begin errors++; $display("FAIL rmid_accept in_ready got 0 want 1"); end
    wait_out(ct, lat, to);
    checks++;
    if (to || lat != 22) begin errors++; $display("FAIL rmid_latency got %0d want 22", lat); end
    ex = pop_exp();
    checks++;
    if (ct !== ex) begin errors++; $display("FAIL rmid_ct got %h want %h", ct, ex); end
    @(negedge clk);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fill_and_c1();
    test_stall();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
